// File: rtl/regfile_mips.sv
// regfile_mips: 2**ADDR_WIDTH x DATA_WIDTH register file for the single-cycle
// MIPS datapath. It has two operand read ports and one debug read port.
// Writes are held in a one-entry staging register for one edge and commit to
// the array on the following edge. Every read port forwards from the live
// write and from the staging register, so a read never returns a stale value.
module regfile_mips #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] dbg_reg,
    output logic [DATA_WIDTH-1:0] reg_data1,
    output logic [DATA_WIDTH-1:0] reg_data2,
    output logic [DATA_WIDTH-1:0] dbg_data,
    output logic                  wb_pending
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  wb_valid;
    logic [ADDR_WIDTH-1:0] wb_reg;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  wr_accept;

    // Writes to register 0 are dropped before they reach the staging register.
    assign wr_accept = reg_write && (write_reg != '0);

    // Read priority: r0 reads as zero, then the live write, then the staging
    // register, then the array.
    function automatic logic [DATA_WIDTH-1:0] resolve(input logic [ADDR_WIDTH-1:0] idx);
        logic [DATA_WIDTH-1:0] val;
        if (idx == '0)
            val = '0;
        else if (wr_accept && (write_reg == idx))
            val = write_data;
        else if (wb_valid && (wb_reg == idx))
            val = wb_data;
        else
            val = regs[idx];
        return val;
    endfunction

    // Array commit from the staging register, followed by the staging load.
    // Reset discards any pending commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            wb_valid <= 1'b0;
            wb_reg   <= '0;
            wb_data  <= '0;
        end else begin
            if (wb_valid)
                regs[wb_reg] <= wb_data;
            wb_valid <= wr_accept;
            if (wr_accept) begin
                wb_reg  <= write_reg;
                wb_data <= write_data;
            end
        end
    end

    // The three read ports resolve independently through the same priority mux.
    always_comb begin
        reg_data1 = resolve(read_reg1);
        reg_data2 = resolve(read_reg2);
        dbg_data  = resolve(dbg_reg);
    end

    assign wb_pending = wb_valid;

endmodule

// File: tb/tb_regfile_mips.sv
// tb_regfile_mips: directed and random stimulus for regfile_mips. Each step
// pushes its expected values to a scoreboard queue as it drives the inputs.
// The queue is popped and compared at the following falling edge.
module tb_regfile_mips;

    logic        clk;
    logic        reset;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  dbg_reg;
    logic [31:0] reg_data1;
    logic [31:0] reg_data2;
    logic [31:0] dbg_data;
    logic        wb_pending;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    // Architectural model: a write is visible as soon as it is presented.
    // The pending flag records whether the previous cycle accepted a write.
    logic [31:0] mem [32];
    logic        m_pend;

    regfile_mips #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .dbg_reg    (dbg_reg),
        .reg_data1  (reg_data1),
        .reg_data2  (reg_data2),
        .dbg_data   (dbg_data),
        .wb_pending (wb_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic rst, input logic rw, input logic [4:0] wr,
                         input logic [31:0] wd, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] dr);
        @(posedge clk);
        #1;
        reset      = rst;
        reg_write  = rw;
        write_reg  = wr;
        write_data = wd;
        read_reg1  = r1;
        read_reg2  = r2;
        dbg_reg    = dr;
    endtask

    task automatic expect_out(input string tag, input int port, input logic [31:0] v);
        exp_t e;
        e.tag  = tag;
        e.port = port;
        e.exp  = v;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (idx == 5'd0)
            return 32'd0;
        if (reg_write && (write_reg == idx))
            return write_data;
        return mem[idx];
    endfunction

    task automatic expect_model(input string tag);
        expect_out({tag, ".d1"}, 0, model_read(read_reg1));
        expect_out({tag, ".d2"}, 1, model_read(read_reg2));
        expect_out({tag, ".dbg"}, 2, model_read(dbg_reg));
        expect_out({tag, ".pend"}, 3, {31'd0, m_pend});
    endtask

    // Compare everything queued for this cycle, then advance the model past
    // the next rising edge.
    task automatic check();
        exp_t        e;
        logic [31:0] obs;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.port)
                0:       obs = reg_data1;
                1:       obs = reg_data2;
                2:       obs = dbg_data;
                default: obs = {31'd0, wb_pending};
            endcase
            total++;
            assert (obs === e.exp) else begin
                bad++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
        if (reset) begin
            for (int i = 0; i < 32; i++)
                mem[i] = 32'd0;
            m_pend = 1'b0;
        end else if (reg_write && (write_reg != 5'd0)) begin
            mem[write_reg] = write_data;
            m_pend = 1'b1;
        end else begin
            m_pend = 1'b0;
        end
    endtask

    initial begin
        logic        rst;
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] wd;

        reset = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
        read_reg1 = '0; read_reg2 = '0; dbg_reg = '0;
        for (int i = 0; i < 32; i++)
            mem[i] = 32'd0;
        m_pend = 1'b0;

        // Reset, then read
        drive(1, 0, 0, 0, 0, 0, 0); check();
        drive(0, 0, 0, 0, 5, 31, 7);
        expect_out("rst.d1", 0, 0); expect_out("rst.d2", 1, 0);
        expect_out("rst.dbg", 2, 0); expect_out("rst.pend", 3, 0);
        check();

        // Basic write: live forward, then staging, then array
        drive(0, 1, 3, 32'h0000_00AA, 3, 0, 3);
        expect_out("wr3.live.d1", 0, 32'hAA); expect_out("wr3.live.dbg", 2, 32'hAA);
        expect_out("wr3.live.pend", 3, 0);
        check();
        drive(0, 0, 0, 0, 3, 0, 0);
        expect_out("wr3.stage.d1", 0, 32'hAA); expect_out("wr3.stage.pend", 3, 1);
        check();
        drive(0, 0, 0, 0, 3, 0, 0);
        expect_out("wr3.array.d1", 0, 32'hAA); expect_out("wr3.array.pend", 3, 0);
        check();

        // Register 0 ignores writes
        drive(0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0);
        expect_out("r0.live.d1", 0, 0); expect_out("r0.live.pend", 3, 0);
        check();
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_out("r0.after.d1", 0, 0); expect_out("r0.after.pend", 3, 0);
        check();

        // Back-to-back writes to the same register
        drive(0, 1, 8, 32'h11, 0, 8, 0);
        expect_out("b2b.c0.d2", 1, 32'h11); check();
        drive(0, 1, 8, 32'h22, 0, 8, 0);
        expect_out("b2b.c1.d2", 1, 32'h22); expect_out("b2b.c1.pend", 3, 1); check();
        drive(0, 0, 0, 0, 0, 8, 0);
        expect_out("b2b.c2.d2", 1, 32'h22); expect_out("b2b.c2.pend", 3, 1); check();
        drive(0, 0, 0, 0, 0, 8, 8);
        expect_out("b2b.c3.d2", 1, 32'h22); expect_out("b2b.c3.dbg", 2, 32'h22);
        expect_out("b2b.c3.pend", 3, 0); check();

        // Back-to-back writes to different registers
        drive(0, 1, 4, 32'h1234, 0, 0, 0); check();
        drive(0, 1, 9, 32'h5678, 0, 0, 0); check();
        drive(0, 0, 0, 0, 4, 9, 0);
        expect_out("diff.c2.d1", 0, 32'h1234); expect_out("diff.c2.d2", 1, 32'h5678); check();
        drive(0, 0, 0, 0, 4, 9, 4);
        expect_out("diff.c3.d1", 0, 32'h1234); expect_out("diff.c3.d2", 1, 32'h5678);
        expect_out("diff.c3.dbg", 2, 32'h1234); check();

        // All three ports on the same index see the live write
        drive(0, 1, 20, 32'hCAFE_F00D, 20, 20, 20);
        expect_out("same.d1", 0, 32'hCAFE_F00D); expect_out("same.d2", 1, 32'hCAFE_F00D);
        expect_out("same.dbg", 2, 32'hCAFE_F00D); check();

        // Reset mid-operation discards the pending and the live write
        drive(0, 1, 12, 32'hDEAD_BEEF, 12, 0, 0);
        expect_out("midrst.live.d1", 0, 32'hDEAD_BEEF); check();
        drive(1, 1, 13, 32'h77, 0, 0, 0); check();
        drive(0, 0, 0, 0, 12, 13, 3);
        expect_out("midrst.r12", 0, 0); expect_out("midrst.r13", 1, 0);
        expect_out("midrst.r3", 2, 0); expect_out("midrst.pend", 3, 0); check();

        // Random traffic against the architectural model
        for (int n = 0; n < 300; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            rw  = ($urandom_range(0, 2) != 0);
            wr  = 5'($urandom_range(0, 31));
            wd  = $urandom;
            drive(rst, rw, wr, wd, 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 1) == 1) ? wr : 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)));
            if (!rst)
                expect_model("rand");
            check();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_mips.md
Name: regfile_mips

Overview:
- Register file that sources the two ALU operands (reg_data1, reg_data2) and sinks the ALU result through a write port.
- Sits between instruction decode and the ALU in the single-cycle MIPS datapath.
- Writes pass through a one-entry write-back staging register before committing to the array.
- All three read ports forward from the live write input and from the staging register, so reads never return stale data.

Parameters:
- DATA_WIDTH, 32, register and data width in bits
- ADDR_WIDTH, 5, register index width; 2**ADDR_WIDTH registers (32)

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears the array and the staging register
- read_reg1  input  ADDR_WIDTH  index for operand 1 (rs)
- read_reg2  input  ADDR_WIDTH  index for operand 2 (rt)
- reg_write  input  1  write enable for this cycle
- write_reg  input  ADDR_WIDTH  destination index (rd/rt)
- write_data  input  DATA_WIDTH  value to write (ALU result or memory data)
- dbg_reg  input  ADDR_WIDTH  debug/testbench read index
- reg_data1  output  DATA_WIDTH  operand 1 to ALU, combinational
- reg_data2  output  DATA_WIDTH  operand 2 to ALU, combinational
- dbg_data  output  DATA_WIDTH  debug read value, same forwarding rules as reg_data1/2
- wb_pending  output  1  staging register holds an uncommitted write

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- State consists of:
  - regs[0..31], each DATA_WIDTH wide
  - wb_valid
  - wb_reg, ADDR_WIDTH wide
  - wb_data, DATA_WIDTH wide
- Reset, sampled at posedge:
  - all regs clear to 0; wb_valid, wb_reg and wb_data clear to 0
  - reset overrides any write in the same cycle, including a pending wb commit, which is discarded
  - after reset: wb_pending=0 and every read port returns 0
- Write acceptance: a write is accepted when reg_write=1 and write_reg!=0. Writes to register 0 are silently dropped and do not load the staging register.
- Each posedge with reset=0, the following happen in the same edge:
  - (a) if wb_valid=1, regs[wb_reg] <= wb_data
  - (b) if a write is accepted: wb_valid<=1, wb_reg<=write_reg, wb_data<=write_data; otherwise wb_valid<=0
- Write latency: data reaches the array 2 edges after being presented. It is readable via forwarding in the same cycle it is presented.
- Read resolution (per port, combinational), in priority order:
  1. index==0 returns 0, regardless of any write.
  2. Index matches an accepted live write (reg_write=1, write_reg==index) returns write_data (write-first).
  3. wb_valid=1 and wb_reg==index returns wb_data.
  4. Otherwise returns regs[index].
- Back-to-back writes to the same register: the newest value always wins under the priority order above. The array commit of the older value is harmless because the staging register is overwritten in the same edge.
- wb_pending = wb_valid (registered output).
- Port independence: the three read ports are fully independent. Identical indices on all three return identical data.
- X-safety: no latch inference; all read muxes fully specified.

Test Plan:
- Reset then read: assert reset 1 cycle; read_reg1=5, read_reg2=31, dbg_reg=7 -> all outputs 0, wb_pending=0.
- Basic write/latency: write reg 3 = 0x0000_00AA (reg_write=1); same cycle read_reg1=3 -> 0xAA (live forward). Next cycle, reg_write=0 -> 0xAA via staging, wb_pending=1. Following cycle -> 0xAA from array, wb_pending=0.
- Register 0: write reg 0 = 0xFFFF_FFFF -> reg_data1 with read_reg1=0 stays 0 in all cycles; wb_pending stays 0.
- Back-to-back same register: write reg 8 = 0x11, next cycle write reg 8 = 0x22, third cycle idle -> read_reg2=8 returns 0x11, 0x22, 0x22, 0x22 on consecutive cycles. Final array value 0x22.
- Back-to-back different registers: write reg 4=0x1234, then reg 9=0x5678 -> two cycles later read_reg1=4 returns 0x1234 and read_reg2=9 returns 0x5678 simultaneously.
- Reset mid-operation: write reg 12 = 0xDEAD_BEEF, assert reset the next cycle with reg_write=1, write_reg=13, write_data=0x77 -> after reset, reg 12 and reg 13 read 0 (13 reads 0 once reg_write is deasserted), wb_pending=0.
